// File: rtl/mem_write_checker.sv
// Bus write checker: compares observed memory writes against a loadable table
// of expected (address, data) pairs and reports pass, failure cause or timeout.
module mem_write_checker #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000,
    localparam int IDXW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNTW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] dataadr,
    input  logic [WIDTH-1:0] writedata,
    input  logic             ld_en,
    input  logic [IDXW-1:0]  ld_idx,
    input  logic [WIDTH-1:0] ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [CNTW-1:0]  num_exp,
    input  logic [1:0]       mode,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       err_code,
    output logic [CNTW-1:0]  match_cnt,
    output logic [WIDTH-1:0] fail_addr,
    output logic [WIDTH-1:0] fail_data
);

    localparam int CYCW = $clog2(TIMEOUT + 1);
    localparam logic [CNTW-1:0] NUM_MAX  = CNTW'(DEPTH);
    localparam logic [CYCW-1:0] CYC_LAST = CYCW'(TIMEOUT - 1);
    localparam logic [CYCW-1:0] CYC_SAT  = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  match_cnt_q, match_cnt_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [WIDTH-1:0] fail_data_q, fail_data_d;
    logic [CYCW-1:0]  cyc_q, cyc_d;
    logic [CNTW-1:0]  num_exp_q, num_exp_d;
    logic [1:0]       mode_q, mode_d;

    logic [WIDTH-1:0] tab_addr_q [DEPTH];
    logic [WIDTH-1:0] tab_data_q [DEPTH];

    logic             start_ok;
    logic [IDXW-1:0]  ptr;
    logic             addr_eq;
    logic             data_eq;

    assign start_ok = start && (num_exp <= NUM_MAX) && (state_q != S_RUN);
    assign ptr      = match_cnt_q[IDXW-1:0];
    assign addr_eq  = (dataadr == tab_addr_q[ptr]);
    assign data_eq  = (writedata == tab_data_q[ptr]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            match_cnt_q <= '0;
            err_code_q  <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            cyc_q       <= '0;
            num_exp_q   <= '0;
            mode_q      <= '0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            err_code_q  <= err_code_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            cyc_q       <= cyc_d;
            num_exp_q   <= num_exp_d;
            mode_q      <= mode_d;
        end
    end

    // Table is deliberately outside reset so entries survive across runs.
    always_ff @(posedge clk) begin
        if (ld_en && !start && (state_q != S_RUN) && ({1'b0, ld_idx} < (IDXW + 1)'(DEPTH))) begin
            tab_addr_q[ld_idx] <= ld_addr;
            tab_data_q[ld_idx] <= ld_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        err_code_d  = err_code_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        cyc_d       = cyc_q;
        num_exp_d   = num_exp_q;
        mode_d      = mode_q;
        case (state_q)
            S_RUN: begin
                if (memwrite) begin
                    if (addr_eq && data_eq) begin
                        match_cnt_d = match_cnt_q + CNTW'(1);
                        if (match_cnt_d == num_exp_q) state_d = S_PASS;
                    end else if (addr_eq && !mode_q[1]) begin
                        state_d     = S_FAIL;
                        err_code_d  = 2'd2;
                        fail_addr_d = dataadr;
                        fail_data_d = writedata;
                    end else if (!addr_eq && !mode_q[0]) begin
                        state_d     = S_FAIL;
                        err_code_d  = 2'd1;
                        fail_addr_d = dataadr;
                        fail_data_d = writedata;
                    end
                end
                // Timeout only applies when this edge made no other decision.
                if (state_d == S_RUN && cyc_q == CYC_LAST) begin
                    state_d    = S_FAIL;
                    err_code_d = 2'd3;
                end
                if (cyc_q != CYC_SAT) cyc_d = cyc_q + CYCW'(1);
            end
            default: begin
                if (start_ok) begin
                    state_d     = (num_exp == '0) ? S_PASS : S_RUN;
                    match_cnt_d = '0;
                    err_code_d  = '0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    cyc_d       = '0;
                    num_exp_d   = num_exp;
                    mode_d      = mode;
                end
            end
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_PASS) || (state_q == S_FAIL);
        pass = (state_q == S_PASS);
    end

    assign err_code  = err_code_q;
    assign match_cnt = match_cnt_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed and randomized bench for mem_write_checker against a run-level
// reference model that replays the write list through the checking rules.
module tb_mem_write_checker;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int TO = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          memwrite;
    logic [W-1:0]  dataadr, writedata;
    logic          ld_en;
    logic [1:0]    ld_idx;
    logic [W-1:0]  ld_addr, ld_data;
    logic [2:0]    num_exp;
    logic [1:0]    mode;
    logic          start;
    logic          busy, done, pass;
    logic [1:0]    err_code;
    logic [2:0]    match_cnt;
    logic [W-1:0]  fail_addr, fail_data;

    mem_write_checker #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .ld_en(ld_en), .ld_idx(ld_idx), .ld_addr(ld_addr),
        .ld_data(ld_data), .num_exp(num_exp), .mode(mode), .start(start),
        .busy(busy), .done(done), .pass(pass), .err_code(err_code),
        .match_cnt(match_cnt), .fail_addr(fail_addr), .fail_data(fail_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] m_addr [D];
    logic [W-1:0] m_data [D];
    logic         wr_en [TO];
    logic [W-1:0] wr_a  [TO];
    logic [W-1:0] wr_d  [TO];
    int           p_m   [TO];
    int           p_cyc, p_pass, p_err, p_fm;
    logic [W-1:0] p_fa, p_fd;
    bit           ld_during_run = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int idx, input logic [W-1:0] a, input logic [W-1:0] d);
        ld_en = 1'b1; ld_idx = 2'(idx); ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
        m_addr[idx] = a;
        m_data[idx] = d;
    endtask

    task automatic clear_wr();
        for (int k = 0; k < TO; k++) begin
            wr_en[k] = 1'b0; wr_a[k] = '0; wr_d[k] = '0;
        end
    endtask

    task automatic set_wr(input int k, input logic [W-1:0] a, input logic [W-1:0] d);
        wr_en[k] = 1'b1; wr_a[k] = a; wr_d[k] = d;
    endtask

    // Outcome of a whole run: walk the write list cycle by cycle, applying the rules.
    task automatic predict(input int n, input logic [1:0] md);
        int m = 0;
        p_pass = 0; p_err = 3; p_fa = '0; p_fd = '0; p_cyc = TO;
        if (n == 0) begin
            p_cyc = 0; p_pass = 1; p_err = 0; p_fm = 0;
            return;
        end
        for (int k = 0; k < TO; k++) begin
            if (wr_en[k]) begin
                if (wr_a[k] == m_addr[m] && wr_d[k] == m_data[m]) begin
                    m++;
                    if (m == n) begin
                        p_m[k] = m; p_cyc = k + 1; p_pass = 1; p_err = 0; p_fm = m;
                        return;
                    end
                end else if ((wr_a[k] == m_addr[m]) ? !md[1] : !md[0]) begin
                    p_err = (wr_a[k] == m_addr[m]) ? 2 : 1;
                    p_fa = wr_a[k]; p_fd = wr_d[k];
                    p_m[k] = m; p_cyc = k + 1; p_fm = m;
                    return;
                end
            end
            p_m[k] = m;
        end
        p_fm = m;
    endtask

    task automatic run(input string tag, input int n, input logic [1:0] md);
        predict(n, md);
        num_exp = 3'(n); mode = md; start = 1'b1;
        tick();
        start = 1'b0;
        num_exp = 3'($urandom_range(0, 4));
        mode = 2'($urandom);
        if (n > 0) begin
            chk({tag, ".busy0"}, busy, 1);
            chk({tag, ".cnt0"}, match_cnt, 0);
            chk({tag, ".err0"}, err_code, 0);
        end
        for (int k = 0; k < p_cyc; k++) begin
            memwrite = wr_en[k]; dataadr = wr_a[k]; writedata = wr_d[k];
            if (ld_during_run && k == 0) begin
                ld_en = 1'b1; ld_idx = 2'd0; ld_addr = 32'hDEAD; ld_data = 32'hBEEF;
            end
            tick();
            ld_en = 1'b0;
            if (k < p_cyc - 1) begin
                chk({tag, ".busy"}, busy, 1);
                chk({tag, ".cnt"}, match_cnt, W'(p_m[k]));
            end
        end
        memwrite = 1'b0;
        chk({tag, ".done"}, done, 1);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".pass"}, pass, W'(p_pass));
        chk({tag, ".err"}, err_code, W'(p_err));
        chk({tag, ".cnt"}, match_cnt, W'(p_fm));
        chk({tag, ".faddr"}, fail_addr, p_fa);
        chk({tag, ".fdata"}, fail_data, p_fd);
        memwrite = 1'b1; dataadr = 32'h300; writedata = $urandom;
        tick();
        memwrite = 1'b0;
        chk({tag, ".sticky_done"}, done, 1);
        chk({tag, ".sticky_pass"}, pass, W'(p_pass));
        chk({tag, ".sticky_err"}, err_code, W'(p_err));
    endtask

    initial begin
        reset = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
        ld_en = 1'b0; ld_idx = '0; ld_addr = '0; ld_data = '0;
        num_exp = '0; mode = '0; start = 1'b0;
        tick();
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.pass", pass, 0);
        chk("rst.err", err_code, 0);
        chk("rst.cnt", match_cnt, 0);
        chk("rst.faddr", fail_addr, 0);
        chk("rst.fdata", fail_data, 0);
        reset = 1'b1;
        tick();

        load(0, 32'h4, 32'hF00D0000);
        clear_wr(); set_wr(0, 32'h4, 32'hF00D0000);
        run("single_pass", 1, 2'b00);
        clear_wr(); set_wr(0, 32'h8, 32'h1234);
        run("wrong_addr", 1, 2'b00);
        clear_wr(); set_wr(0, 32'h4, 32'h0);
        run("wrong_data", 1, 2'b00);
        clear_wr(); set_wr(0, 32'h4, 32'h0); set_wr(1, 32'h4, 32'hF00D0000);
        run("ign_data", 1, 2'b10);
        clear_wr();
        run("timeout", 1, 2'b00);
        clear_wr(); set_wr(TO - 1, 32'h4, 32'hF00D0000);
        run("last_cycle_match", 1, 2'b00);
        clear_wr();
        run("zero_exp", 0, 2'b00);

        load(0, 32'h0, 32'hA); load(1, 32'h4, 32'hB);
        load(2, 32'h8, 32'hC); load(3, 32'hC, 32'hD);
        clear_wr();
        set_wr(0, 32'h0, 32'hA); set_wr(1, 32'h100, 32'h55); set_wr(2, 32'h4, 32'hB);
        set_wr(3, 32'h100, 32'h66); set_wr(4, 32'h8, 32'hC); set_wr(5, 32'hC, 32'hD);
        run("four_foreign", 4, 2'b01);

        // Oversized num_exp is refused and a load alongside start is dropped.
        num_exp = 3'd5; start = 1'b1; ld_en = 1'b1; ld_idx = 2'd0;
        ld_addr = 32'h77; ld_data = 32'h77;
        tick();
        start = 1'b0; ld_en = 1'b0;
        chk("big_exp.busy", busy, 0);
        chk("big_exp.pass", pass, 1);
        ld_during_run = 1;
        clear_wr(); set_wr(1, 32'h0, 32'hA);
        run("ld_in_run", 1, 2'b00);
        ld_during_run = 0;

        num_exp = 3'd4; mode = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        memwrite = 1'b1; dataadr = 32'h0; writedata = 32'hA;
        tick();
        dataadr = 32'h4; writedata = 32'hB;
        tick();
        memwrite = 1'b0;
        chk("mid_rst.pre_cnt", match_cnt, 2);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst.busy", busy, 0);
        chk("mid_rst.cnt", match_cnt, 0);
        chk("mid_rst.done", done, 0);
        chk("mid_rst.err", err_code, 0);
        tick();
        reset = 1'b1;
        tick();
        clear_wr();
        set_wr(0, 32'h0, 32'hA); set_wr(1, 32'h4, 32'hB);
        set_wr(2, 32'h8, 32'hC); set_wr(3, 32'hC, 32'hD);
        run("after_rst", 4, 2'b00);

        for (int r = 0; r < 40; r++) begin
            int gp = 0;
            for (int i = 0; i < D; i++)
                load(i, 32'(4 * $urandom_range(0, 3)), 32'($urandom_range(0, 3)));
            clear_wr();
            for (int k = 0; k < TO; k++) begin
                int c = $urandom_range(0, 9);
                if (c < 5 && gp < D) begin
                    set_wr(k, m_addr[gp], m_data[gp]); gp++;
                end else if (c < 7) begin
                    set_wr(k, m_addr[gp % D], m_data[gp % D] ^ 32'h1);
                end else if (c < 9) begin
                    set_wr(k, 32'h200 + 32'($urandom_range(0, 3)), $urandom);
                end
            end
            run("random", $urandom_range(0, D), 2'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 32, address/data width.
REQ-002 SHALL have parameter DEPTH, default 4, number of expected-write table entries (>=1).
REQ-003 SHALL have parameter TIMEOUT, default 1000, RUN cycles allowed before timeout (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port memwrite  input  1  observed bus write strobe.
REQ-007 SHALL have port dataadr  input  WIDTH  observed write address.
REQ-008 SHALL have port writedata  input  WIDTH  observed write data.
REQ-009 SHALL have port ld_en  input  1  load one table entry.
REQ-010 SHALL have port ld_idx  input  clog2(DEPTH)  table entry index.
REQ-011 SHALL have port ld_addr  input  WIDTH  expected address for entry.
REQ-012 SHALL have port ld_data  input  WIDTH  expected data for entry.
REQ-013 SHALL have port num_exp  input  clog2(DEPTH+1)  expected writes this run.
REQ-014 SHALL have port mode  input  2  bit0 ignore foreign-address writes; bit1 ignore data mismatch at expected address.
REQ-015 SHALL have port start  input  1  begin a run.
REQ-016 SHALL have port busy  output  1  high in RUN.
REQ-017 SHALL have port done  output  1  high in PASS or FAIL.
REQ-018 SHALL have port pass  output  1  high in PASS only.
REQ-019 SHALL have port err_code  output  2  0 none, 1 wrong address, 2 wrong data, 3 timeout.
REQ-020 SHALL have port match_cnt  output  clog2(DEPTH+1)  expected writes matched so far.
REQ-021 SHALL have ports fail_addr, fail_data  output  WIDTH each  offending write captured at failure; 0 on timeout.

Function
REQ-022 SHALL implement states IDLE, RUN, PASS, FAIL.
REQ-023 ld_en SHALL write table entry ld_idx in IDLE, PASS or FAIL; SHALL be ignored in RUN or when start is high.
REQ-024 start with num_exp<=DEPTH SHALL, from IDLE/PASS/FAIL, clear match_cnt, err_code, fail_*, cycle counter and enter RUN next cycle; start with num_exp>DEPTH SHALL be ignored; start in RUN SHALL be ignored.
REQ-025 start with num_exp=0 SHALL go directly to PASS next cycle.
REQ-026 num_exp and mode SHALL be latched at start and held for the run.
REQ-027 In RUN, each edge with memwrite=1 SHALL compare against entry ptr=match_cnt.
REQ-028 Address and data equal: match_cnt increments; if new match_cnt==num_exp, next state PASS.
REQ-029 Address equal, data differs: mode[1]=1 ignore; else FAIL, err_code=2.
REQ-030 Address differs: mode[0]=1 ignore; else FAIL, err_code=1.
REQ-031 Cycle counter SHALL count RUN cycles; on the edge where it reaches TIMEOUT-1 with no completing match, next state FAIL, err_code=3.
REQ-032 Final match and timeout on the same edge SHALL yield PASS.
REQ-033 pass/done/err_code/match_cnt SHALL update one cycle after the deciding edge (registered outputs).
REQ-034 PASS and FAIL SHALL be sticky until start or reset.
REQ-035 Cycle counter SHALL saturate, never wrap.

Reset
REQ-036 reset=0 SHALL immediately force IDLE, busy=done=pass=0, err_code=0, match_cnt=0, fail_*=0, counter=0, including mid-RUN.
REQ-037 Table contents SHALL NOT be reset; they SHALL persist across runs.

Verification
REQ-038 Load entry0 = (4, F00D0000), num_exp=1, mode=0, start; write (4, F00D0000) -> pass=1, done=1, err_code=0, match_cnt=1 next cycle.
REQ-039 Same table, mode=0; write (8, 1234) -> FAIL, err_code=1, fail_addr=8, fail_data=1234.
REQ-040 Same table, mode=2'b10; write (4, 0), then (4, F00D0000) -> first ignored, then PASS, match_cnt=1.
REQ-041 TIMEOUT=10, mode=0, no writes -> FAIL, err_code=3, after 10 RUN cycles; with final match on cycle 10 -> PASS.
REQ-042 Four entries (0,A),(4,B),(8,C),(C,D), num_exp=4, mode=1; interleave foreign writes to 0x100 -> PASS, match_cnt=4.
REQ-043 reset=0 mid-RUN after 2 matches -> IDLE, match_cnt=0, busy=0; restart without reload -> table reused, PASS.
